desired_drive_slew: RTL and testbench

//   Parametrised, pipelined successor of the e-bike assist-current calculator.

---
 rtl/desired_drive_slew.sv | 129 ++++++++++++
 tb/tb_desired_drive_slew.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/desired_drive_slew.sv
// Pipelined assist-current calculator: torque/cadence/incline sample to a
// slew-limited motor target current, three cycles from smpl_vld to target_vld.
module desired_drive_slew #(
    parameter int unsigned          TORQUE_W   = 12,
    parameter int unsigned          CURR_W     = 12,
    parameter logic [TORQUE_W-1:0]  TORQUE_MIN = 12'h380,
    parameter int unsigned          PROD_SHIFT = 15,
    parameter logic [CURR_W-1:0]    SLEW_STEP  = 12'h040
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                smpl_vld,
    input  logic [TORQUE_W-1:0] avg_torque,
    input  logic [4:0]          cadence,
    input  logic                not_pedaling,
    input  logic signed [12:0]  incline,
    input  logic [2:0]          scale,
    output logic [CURR_W-1:0]   target_curr,
    output logic                target_vld
);

    localparam int unsigned TPROD_W = TORQUE_W + 3;
    localparam int unsigned IPROD_W = 15;
    localparam int unsigned PROD_W  = TPROD_W + IPROD_W;

    // Stage 1 combinational terms
    logic [TORQUE_W-1:0]  torque_pos;
    logic [TPROD_W-1:0]   tprod_d, tprod_q;
    logic signed [9:0]    incl_sat;
    logic signed [10:0]   incl_fac;
    logic [8:0]           incl_lim;
    logic [5:0]           cad_f;
    logic [IPROD_W-1:0]   iprod_d, iprod_q;
    logic                 np1_q, v1_q;

    // Stage 2
    logic [PROD_W-1:0]    prod_d, prod_q;
    logic                 np2_q, v2_q;

    // Stage 3
    logic [PROD_W-1:0]    shifted;
    logic [CURR_W-1:0]    raw;
    logic [CURR_W:0]      step_sum;
    logic [CURR_W-1:0]    curr_d;

    always_comb begin
        torque_pos = '0;
        if (avg_torque >= TORQUE_MIN) begin
            torque_pos = avg_torque - TORQUE_MIN;
        end
        tprod_d = TPROD_W'(torque_pos) * TPROD_W'(scale);

        if (incline < -13'sd512) begin
            incl_sat = -10'sd512;
        end else if (incline > 13'sd511) begin
            incl_sat = 10'sd511;
        end else begin
            incl_sat = $signed(incline[9:0]);
        end
        incl_fac = $signed({incl_sat[9], incl_sat}) + 11'sd256;

        if (incl_fac[10]) begin
            incl_lim = '0;
        end else if (incl_fac > 11'sd511) begin
            incl_lim = 9'd511;
        end else begin
            incl_lim = incl_fac[8:0];
        end

        cad_f = '0;
        if (cadence > 5'd1) begin
            cad_f = {1'b0, cadence} + 6'd32;
        end
        iprod_d = IPROD_W'(incl_lim) * IPROD_W'(cad_f);
    end

    always_comb begin
        prod_d = '0;
        if (!np1_q) begin
            prod_d = PROD_W'(tprod_q) * PROD_W'(iprod_q);
        end
    end

    always_comb begin
        shifted = prod_q >> PROD_SHIFT;
        raw     = shifted[CURR_W-1:0];
        if ((shifted >> CURR_W) != '0) begin
            raw = '1;
        end
        // One bit wider so a near-full-scale current cannot wrap to a small value
        step_sum = {1'b0, target_curr} + {1'b0, SLEW_STEP};

        curr_d = target_curr;
        if (v2_q) begin
            if (np2_q) begin
                curr_d = '0;
            end else if ({1'b0, raw} > step_sum) begin
                curr_d = step_sum[CURR_W-1:0];
            end else begin
                curr_d = raw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tprod_q     <= '0;
            iprod_q     <= '0;
            np1_q       <= 1'b0;
            v1_q        <= 1'b0;
            prod_q      <= '0;
            np2_q       <= 1'b0;
            v2_q        <= 1'b0;
            target_curr <= '0;
            target_vld  <= 1'b0;
        end else begin
            tprod_q     <= tprod_d;
            iprod_q     <= iprod_d;
            np1_q       <= not_pedaling;
            v1_q        <= smpl_vld;
            prod_q      <= prod_d;
            np2_q       <= np1_q;
            v2_q        <= v1_q;
            target_curr <= curr_d;
            target_vld  <= v2_q;
        end
    end

endmodule

// File: tb/tb_desired_drive_slew.sv
// Scoreboard bench for desired_drive_slew: directed samples push hand-computed
// results; a negedge monitor pops and checks value and 3-cycle latency.
module tb_desired_drive_slew;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               smpl_vld;
    logic [11:0]        avg_torque;
    logic [4:0]         cadence;
    logic               not_pedaling;
    logic signed [12:0] incline;
    logic [2:0]         scale;
    logic [11:0]        target_curr;
    logic               target_vld;

    typedef struct {
        logic [11:0] curr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    desired_drive_slew dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .smpl_vld     (smpl_vld),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .incline      (incline),
        .scale        (scale),
        .target_curr  (target_curr),
        .target_vld   (target_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every target_vld pulse must match the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && target_vld) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL vld_unexpected: target_vld=1 curr=%h at cycle %0d, required no pulse",
                             target_curr, cyc);
                end else begin
                    e = q.pop_front();
                    if (target_curr !== e.curr || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL result: curr=%h cycle=%0d, required curr=%h cycle=%0d",
                                 target_curr, cyc, e.curr, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [11:0] t, input logic [4:0] c, input logic np,
                        input logic signed [12:0] inc, input logic [2:0] s,
                        input logic [11:0] exp_curr);
        exp_t e;
        @(posedge clk);
        #1;
        smpl_vld     = 1'b1;
        avg_torque   = t;
        cadence      = c;
        not_pedaling = np;
        incline      = inc;
        scale        = s;
        e.curr = exp_curr;
        e.cyc  = cyc + 3;
        q.push_back(e);
    endtask

    // Basic sample: raw = 0x140
    task automatic send_b(input logic [11:0] exp_curr);
        send(12'h480, 5'd8, 1'b0, 13'sd0, 3'd4, exp_curr);
    endtask

    task automatic ramp_b();
        for (int k = 1; k <= 5; k++) send_b(12'(k * 'h40));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            smpl_vld   = 1'b0;
            avg_torque = 12'(avg_torque + 12'h123);
            cadence    = cadence + 5'd3;
            incline    = incline - 13'sd77;
            scale      = scale + 3'd1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        smpl_vld     = 1'b0;
        avg_torque   = '0;
        cadence      = '0;
        not_pedaling = 1'b0;
        incline      = '0;
        scale        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_curr", target_curr, 12'h000);
        check("reset_vld", {11'd0, target_vld}, 12'h000);
        #2 rst_n = 1'b1;

        // Basic ramp and hold at raw
        ramp_b();
        send_b(12'h140);

        // Cut-offs from 0x140
        send(12'h480, 5'd8, 1'b0, -13'sd300, 3'd4, 12'h000);
        ramp_b();
        send(12'h480, 5'd1, 1'b0, 13'sd0, 3'd4, 12'h000);
        ramp_b();
        send(12'h300, 5'd8, 1'b0, 13'sd0, 3'd4, 12'h000);
        ramp_b();
        send(12'h480, 5'd8, 1'b1, 13'sd0, 3'd4, 12'h000);

        // Back-to-back alternating raw 0x140 / 0x000
        send_b(12'h040);
        send(12'h300, 5'd8, 1'b0, 13'sd0, 3'd4, 12'h000);
        send_b(12'h040);
        send(12'h300, 5'd8, 1'b0, 13'sd0, 3'd4, 12'h000);
        send_b(12'h040);
        send_b(12'h080);
        send(12'h300, 5'd8, 1'b0, 13'sd0, 3'd4, 12'h000);

        // Saturation: ramp to 0xFFF and hold
        for (int k = 1; k <= 66; k++) begin
            send(12'hFFF, 5'd31, 1'b0, 13'sd511, 3'd7, (k >= 64) ? 12'hFFF : 12'(k * 'h40));
        end

        // Idle hold
        idle(4);
        drain();
        for (int i = 0; i < 16; i++) begin
            idle(1);
            @(negedge clk);
            check("idle_hold", target_curr, 12'hFFF);
        end

        // Reset with two samples in flight
        send_b(12'h140);
        send_b(12'h140);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midreset_curr", target_curr, 12'h000);
        check("midreset_vld", {11'd0, target_vld}, 12'h000);
        smpl_vld = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_curr", target_curr, 12'h000);
        send_b(12'h040);
        idle(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
